edge_pixel_source: RTL and testbench

- Raster pixel transmitter that feeds the Sobel edge stage.
- Reads RGB444 pixels from a synchronous-read frame RAM in raster order and emits them on a 12-bit bus, with a one-cycle `ready` strobe per pixel.
- Inserts programmable horizontal and vertical blanking, and marks start-of-frame and end-of-line.
- Runs continuously frame after frame until stopped; a stop takes effect only at a frame boundary.

---
 rtl/edge_pixel_source.sv | 203 ++++++++++++++++++++
 tb/tb_edge_pixel_source.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pixel_source.sv
// Raster pixel source for the Sobel edge stage: streams RGB444 pixels from a synchronous-read
// frame RAM with programmable horizontal/vertical blanking, sof/eol markers and frame-boundary stop.
module edge_pixel_source #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned HBLANK = 16,
    parameter int unsigned VBLANK = 2,
    parameter int unsigned DIV    = 4,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rd_data,
    output logic [11:0]       video_out,
    output logic              ready,
    output logic              sof,
    output logic              eol,
    output logic              busy
);

    localparam int unsigned V_SLOTS = VBLANK * (WIDTH + HBLANK);
    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned DW = $clog2(DIV);
    localparam int unsigned HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam int unsigned VW = (V_SLOTS > 1) ? $clog2(V_SLOTS) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [VW-1:0] V_LAST   = VW'((V_SLOTS > 0) ? V_SLOTS - 1 : 0);

    typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              ready_q, ready_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic [11:0]       video_q;
    logic              tick;
    logic              line_end;
    logic              frame_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            ready_q     <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            video_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            stop_pend_q <= stop_pend_d;
            ready_q     <= ready_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            if (ready_q) begin
                video_q <= mem_rd_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        stop_pend_d = stop_pend_q;
        ready_d     = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        mem_rd_en   = 1'b0;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        tick        = (state_q != StIdle) && (div_q == '0);

        if (state_q != StIdle) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (stop) begin
                stop_pend_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StActive;
                    div_d       = '0;
                    x_d         = '0;
                    y_d         = '0;
                    addr_d      = '0;
                    stop_pend_d = 1'b0;
                end
            end
            StActive: begin
                if (tick) begin
                    mem_rd_en = 1'b1;
                    ready_d   = 1'b1;
                    sof_d     = (x_q == '0) && (y_q == '0);
                    eol_d     = (x_q == X_LAST);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        // Wrap on the last pixel so mem_addr never leaves the frame.
                        addr_d = (y_q == Y_LAST) ? '0 : addr_q + 1'b1;
                        if (HBLANK > 0) begin
                            state_d = StHblank;
                            hcnt_d  = '0;
                        end else begin
                            line_end = 1'b1;
                        end
                    end else begin
                        x_d    = x_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StHblank: begin
                if (tick) begin
                    if (hcnt_q == H_LAST) begin
                        line_end = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            StVblank: begin
                if (tick) begin
                    if (vcnt_q == V_LAST) begin
                        frame_end = 1'b1;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (line_end) begin
            if (y_q == Y_LAST) begin
                y_d = '0;
                if (V_SLOTS > 0) begin
                    state_d = StVblank;
                    vcnt_d  = '0;
                end else begin
                    frame_end = 1'b1;
                end
            end else begin
                y_d     = y_q + 1'b1;
                state_d = StActive;
            end
        end

        if (frame_end) begin
            if (stop_pend_q || stop) begin
                state_d     = StIdle;
                div_d       = '0;
                stop_pend_d = 1'b0;
            end else begin
                state_d = StActive;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
            end
        end
    end

    // RAM data lands in the strobe cycle, so pass it straight through then and hold it after.
    assign video_out = ready_q ? mem_rd_data : video_q;
    assign ready     = ready_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign mem_addr  = addr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_edge_pixel_source.sv
// Bench for edge_pixel_source: a slot-timing model predicts every read and strobe; expected
// pixels are queued at read time and compared when the DUT strobes ready.
module tb_edge_pixel_source;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int HB     = 2;
    localparam int VB     = 1;
    localparam int DV     = 2;
    localparam int AW     = 4;
    localparam int LINE   = W + HB;
    localparam int FSLOTS = (H + VB) * LINE;
    localparam int FRAME  = FSLOTS * DV;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_rd_data;
    logic [11:0]   video_out;
    logic          ready, sof, eol, busy;

    edge_pixel_source #(
        .WIDTH (W),
        .HEIGHT(H),
        .HBLANK(HB),
        .VBLANK(VB),
        .DIV   (DV),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .video_out  (video_out),
        .ready      (ready),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 12'h100 + 12'(i);
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [11:0] pix;
        logic        s;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    bit          mon_en = 1'b0;
    bit          run = 1'b0;
    int          n0 = 0;
    int          end_j = 0;
    logic [11:0] exp_video = '0;

    function automatic bit slot_read(int j);
        int f;
        if (j < 0 || (j % DV) != 0) return 1'b0;
        f = (j / DV) % FSLOTS;
        return (f / LINE < H) && (f % LINE < W);
    endfunction

    function automatic int slot_addr(int j);
        int f;
        f = (j / DV) % FSLOTS;
        return (f / LINE) * W + (f % LINE);
    endfunction

    always @(negedge clk) begin : monitor
        int   j, a;
        bit   live, exp_rd, exp_rdy;
        exp_t e;
        if (mon_en) begin
            j       = cyc - n0;
            live    = run && (j >= 0) && (j < end_j);
            exp_rd  = live && slot_read(j);
            exp_rdy = run && slot_read(j - 1) && ((j - 1) < end_j);
            check("busy", 32'(busy), 32'(live));
            check("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
            check("addr_bound", 32'(mem_addr <= AW'(W * H - 1)), 32'd1);
            if (exp_rd) begin
                a = slot_addr(j);
                check("mem_addr", 32'(mem_addr), 32'(a));
                sb.push_back('{12'h100 + 12'(a), a == 0, (a % W) == W - 1});
            end
            check("ready", 32'(ready), 32'(exp_rdy));
            if (exp_rdy && sb.size() > 0) begin
                e         = sb.pop_front();
                exp_video = e.pix;
                check("sof", 32'(sof), 32'(e.s));
                check("eol", 32'(eol), 32'(e.e));
            end else begin
                check("sof_idle", 32'(sof), 32'd0);
                check("eol_idle", 32'(eol), 32'd0);
            end
            check("video_out", 32'(video_out), 32'(exp_video));
        end
    end

    task automatic start_run(input logic with_stop);
        @(posedge clk); #1;
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        n0    = cyc;
        run   = 1'b1;
        end_j = 1 << 30;
    endtask

    // Returns the cycle of the next sof and how many non-sof strobes preceded it.
    task automatic wait_sof(input string tag, output int c, output int n_rdy);
        bit found = 1'b0;
        n_rdy = 0;
        c     = cyc;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (sof) begin
                found = 1'b1;
                c     = cyc;
            end else if (ready) begin
                n_rdy++;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_pixel(input string tag, input logic [11:0] v);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ready && video_out === v) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic stop_and_drain(input string tag);
        int  s;
        bit  found = 1'b0;
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk);
        s = cyc;
        #1;
        stop  = 1'b0;
        end_j = FRAME * ((s - n0) / FRAME) + FRAME - 1;
        // A repeated stop must not change the frame end.
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        check({tag, "_busy_drop"}, 32'(found), 32'd1);
        check({tag, "_drop_cycle"}, 32'(cyc - n0), 32'(end_j));
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int c0, c1, nr;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_video", 32'(video_out), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // First frame, wrap into second, start while busy, stop mid line 2.
        start_run(1'b0);
        wait_sof("sof1_seen", c0, nr);
        check("sof1_latency", 32'(c0 - n0), 32'd1);
        check("sof1_pixel", 32'(video_out), 32'h100);
        wait_sof("sof2_seen", c1, nr);
        check("frame_period", 32'(c1 - c0), 32'(FRAME));
        check("ready_per_frame", 32'(nr + 1), 32'(W * H));
        check("sof2_pixel", 32'(video_out), 32'h100);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_pixel("see_109", 12'h109);
        stop_and_drain("stop1");

        // Restart after stop begins at pixel 0 with sof.
        start_run(1'b0);
        wait_sof("restart_sof", c0, nr);
        check("restart_latency", 32'(c0 - n0), 32'd1);
        check("restart_pixel", 32'(video_out), 32'h100);
        stop_and_drain("stop2");

        // start+stop together in idle: stop discarded, runs past a full frame.
        start_run(1'b1);
        wait_sof("ss_sof1", c0, nr);
        wait_sof("ss_sof2", c1, nr);
        check("ss_period", 32'(c1 - c0), 32'(FRAME));

        // Reset mid-line aborts at once.
        wait_pixel("see_105", 12'h105);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run       = 1'b0;
        exp_video = '0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_video", 32'(video_out), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        start_run(1'b0);
        wait_sof("post_rst_sof", c0, nr);
        check("post_rst_latency", 32'(c0 - n0), 32'd1);
        check("post_rst_pixel", 32'(video_out), 32'h100);
        stop_and_drain("stop3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
